// File: rtl/wave_pkg.sv
// Shared waveform definitions: sample/period widths, midline code, hysteresis
// and the monitor state encoding.
package wave_pkg;

  localparam int unsigned DefDataW    = 10;
  localparam int unsigned DefPeriodW  = 16;
  localparam int unsigned DefMidpoint = 512;
  localparam int unsigned DefHyst     = 8;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StSeekLow  = 3'd1,
    StWaitRise = 3'd2,
    StMeasHigh = 3'd3,
    StMeasLow  = 3'd4
  } mon_state_t;

endpackage

// File: rtl/hyst_compare.sv
// Combinational hysteresis classifier: flags samples at or beyond the upper
// and lower thresholds around the midline; anything between is dead band.
module hyst_compare
  import wave_pkg::*;
#(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned MIDPOINT = DefMidpoint,
  parameter int unsigned HYST     = DefHyst
) (
  input  logic [DATA_W-1:0] sample_i,
  output logic              above_o,
  output logic              below_o
);

  // One extra bit so MIDPOINT+HYST cannot wrap at the top of the code range.
  localparam logic [DATA_W:0] HiThr = (DATA_W + 1)'(MIDPOINT + HYST);
  localparam logic [DATA_W:0] LoThr = (DATA_W + 1)'(MIDPOINT - HYST);

  always_comb begin
    above_o = ({1'b0, sample_i} >= HiThr);
    below_o = ({1'b0, sample_i} <= LoThr);
  end

endmodule

// File: rtl/waveform_monitor.sv
// Per-cycle waveform measurement: period between rising midline crossings,
// peak, trough, amplitude, period lock and no-crossing timeout.
module waveform_monitor
  import wave_pkg::*;
#(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned MIDPOINT = DefMidpoint,
  parameter int unsigned HYST     = DefHyst,
  parameter int unsigned PERIOD_W = DefPeriodW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_valid,
  input  logic [DATA_W-1:0]   sample_data,
  output logic                meas_valid,
  output logic [PERIOD_W-1:0] period,
  output logic [DATA_W-1:0]   peak,
  output logic [DATA_W-1:0]   trough,
  output logic [DATA_W-1:0]   amplitude,
  output logic                locked,
  output logic                timeout
);

  localparam logic [PERIOD_W-1:0] CntMax = '1;

  mon_state_t          state_q, state_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0]   min_q, min_d;
  logic [DATA_W-1:0]   max_q, max_d;
  logic                prev_ok_q, prev_ok_d;
  logic                meas_valid_q, meas_valid_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [DATA_W-1:0]   peak_q, peak_d;
  logic [DATA_W-1:0]   trough_q, trough_d;
  logic [DATA_W-1:0]   amp_q, amp_d;
  logic                locked_q, locked_d;
  logic                timeout_q, timeout_d;

  logic above, below;

  hyst_compare #(
    .DATA_W   (DATA_W),
    .MIDPOINT (MIDPOINT),
    .HYST     (HYST)
  ) u_hyst_compare (
    .sample_i (sample_data),
    .above_o  (above),
    .below_o  (below)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    min_d        = min_q;
    max_d        = max_q;
    prev_ok_d    = prev_ok_q;
    period_d     = period_q;
    peak_d       = peak_q;
    trough_d     = trough_q;
    amp_d        = amp_q;
    locked_d     = locked_q;
    meas_valid_d = 1'b0;
    timeout_d    = 1'b0;

    if (sample_valid) begin
      unique case (state_q)
        StIdle: state_d = StSeekLow;
        StSeekLow: begin
          if (below) state_d = StWaitRise;
        end
        StWaitRise: begin
          if (above) begin
            state_d = StMeasHigh;
            cnt_d   = PERIOD_W'(1);
            min_d   = sample_data;
            max_d   = sample_data;
          end
        end
        StMeasHigh, StMeasLow: begin
          if ((state_q == StMeasLow) && above) begin
            // Rising crossing closes the cycle; this sample opens the next one.
            meas_valid_d = 1'b1;
            period_d     = cnt_q;
            peak_d       = max_q;
            trough_d     = min_q;
            amp_d        = max_q - min_q;
            locked_d     = prev_ok_q && (cnt_q == period_q);
            prev_ok_d    = 1'b1;
            state_d      = StMeasHigh;
            cnt_d        = PERIOD_W'(1);
            min_d        = sample_data;
            max_d        = sample_data;
          end else if (cnt_q == CntMax) begin
            timeout_d = 1'b1;
            locked_d  = 1'b0;
            prev_ok_d = 1'b0;
            state_d   = StSeekLow;
          end else begin
            cnt_d = cnt_q + PERIOD_W'(1);
            if (sample_data < min_q) min_d = sample_data;
            if (sample_data > max_q) max_d = sample_data;
            if ((state_q == StMeasHigh) && below) state_d = StMeasLow;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      min_q        <= '0;
      max_q        <= '0;
      prev_ok_q    <= 1'b0;
      meas_valid_q <= 1'b0;
      period_q     <= '0;
      peak_q       <= '0;
      trough_q     <= '0;
      amp_q        <= '0;
      locked_q     <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      min_q        <= min_d;
      max_q        <= max_d;
      prev_ok_q    <= prev_ok_d;
      meas_valid_q <= meas_valid_d;
      period_q     <= period_d;
      peak_q       <= peak_d;
      trough_q     <= trough_d;
      amp_q        <= amp_d;
      locked_q     <= locked_d;
      timeout_q    <= timeout_d;
    end
  end

  assign meas_valid = meas_valid_q;
  assign period     = period_q;
  assign peak       = peak_q;
  assign trough     = trough_q;
  assign amplitude  = amp_q;
  assign locked     = locked_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_waveform_monitor.sv
// Directed bench for waveform_monitor: vector table plus sine, noise, timeout
// and period-switch sequences.
module tb_waveform_monitor;
  import wave_pkg::*;

  localparam int DW = 10;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sample_valid = 1'b0;
  logic [DW-1:0] sample_data = '0;
  logic          meas_valid;
  logic [PW-1:0] period;
  logic [DW-1:0] peak, trough, amplitude;
  logic          locked, timeout;

  always #5 clk = ~clk;

  waveform_monitor dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .meas_valid   (meas_valid),
    .period       (period),
    .peak         (peak),
    .trough       (trough),
    .amplitude    (amplitude),
    .locked       (locked),
    .timeout      (timeout)
  );

  typedef struct {
    logic v;
    int   d;
    logic mv;
    int   per;
    int   pk;
    int   tr;
    int   amp;
    logic lk;
    logic to;
  } vec_t;

  int errors = 0;
  int checks = 0;

  int pub_idx[$];
  int pub_per[$];
  int pub_pk[$];
  int pub_tr[$];
  int pub_amp[$];
  int pub_lk[$];
  int vidx;
  int to_cnt;
  int bad_pulse;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_log();
    pub_idx.delete(); pub_per.delete(); pub_pk.delete();
    pub_tr.delete(); pub_amp.delete(); pub_lk.delete();
    vidx = 0; to_cnt = 0; bad_pulse = 0;
  endtask

  // Apply one input for one edge, then sample outputs #1 after that edge.
  task automatic step(input logic v, input int d);
    sample_valid = v;
    sample_data  = d[DW-1:0];
    @(posedge clk);
    #1;
    if ((meas_valid || timeout) && !v) bad_pulse++;
    if (meas_valid) begin
      pub_idx.push_back(vidx);
      pub_per.push_back(int'(period));
      pub_pk.push_back(int'(peak));
      pub_tr.push_back(int'(trough));
      pub_amp.push_back(int'(amplitude));
      pub_lk.push_back(int'(locked));
    end
    if (timeout) to_cnt++;
    if (v) vidx++;
  endtask

  task automatic do_reset(input bit check_outs);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 700 - 100 * i);
      if (check_outs) begin
        chk("rst_meas_valid", int'(meas_valid), 0);
        chk("rst_period", int'(period), 0);
        chk("rst_peak_trough_amp", int'(peak) + int'(trough) + int'(amplitude), 0);
        chk("rst_locked_timeout", int'(locked) + int'(timeout), 0);
        chk("rst_state", int'(dut.state_q), int'(StIdle));
      end
    end
    rst_n = 1'b1;
    clear_log();
  endtask

  function automatic int sine(input int n, input int per);
    real r;
    int  s;
    r = 512.0 + 511.5 * $sin(2.0 * 3.14159265358979 * real'(n) / real'(per));
    s = $rtoi(r);
    if (s < 0) s = 0;
    if (s > 1023) s = 1023;
    return s;
  endfunction

  task automatic chk_pub(input string name, input int k, input int per, input int pk,
                         input int tr, input int lk);
    if (pub_per.size() <= k) begin
      chk({name, "_present"}, pub_per.size(), k + 1);
    end else begin
      chk({name, "_period"}, pub_per[k], per);
      chk({name, "_peak"}, pub_pk[k], pk);
      chk({name, "_trough"}, pub_tr[k], tr);
      chk({name, "_amplitude"}, pub_amp[k], pk - tr);
      chk({name, "_locked"}, pub_lk[k], lk);
    end
  endtask

  vec_t tbl[17];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    //          v  d     mv per pk    tr   amp   lk to
    tbl[0]  = '{1, 600,  0, 0, 0,    0,   0,    0, 0};
    tbl[1]  = '{1, 504,  0, 0, 0,    0,   0,    0, 0};
    tbl[2]  = '{1, 520,  0, 0, 0,    0,   0,    0, 0};
    tbl[3]  = '{1, 700,  0, 0, 0,    0,   0,    0, 0};
    tbl[4]  = '{0, 0,    0, 0, 0,    0,   0,    0, 0};
    tbl[5]  = '{1, 300,  0, 0, 0,    0,   0,    0, 0};
    tbl[6]  = '{1, 505,  0, 0, 0,    0,   0,    0, 0};
    tbl[7]  = '{1, 519,  0, 0, 0,    0,   0,    0, 0};
    tbl[8]  = '{1, 600,  1, 5, 700,  300, 400,  0, 0};
    tbl[9]  = '{1, 100,  0, 5, 700,  300, 400,  0, 0};
    tbl[10] = '{1, 900,  1, 2, 600,  100, 500,  0, 0};
    tbl[11] = '{1, 50,   0, 2, 600,  100, 500,  0, 0};
    tbl[12] = '{1, 1023, 1, 2, 900,  50,  850,  1, 0};
    tbl[13] = '{0, 1023, 0, 2, 900,  50,  850,  1, 0};
    tbl[14] = '{1, 512,  0, 2, 900,  50,  850,  1, 0};
    tbl[15] = '{1, 0,    0, 2, 900,  50,  850,  1, 0};
    tbl[16] = '{1, 1000, 1, 3, 1023, 0,   1023, 0, 0};

    // Reset with valid samples driven, then first sample arms the FSM.
    clear_log();
    do_reset(1'b1);
    step(1'b1, 600);
    chk("arm_state_seek_low", int'(dut.state_q), int'(StSeekLow));

    // Vector table, including exact threshold codes 504/520 and dead-band 505/519.
    do_reset(1'b0);
    for (int r = 0; r < 17; r++) begin
      step(tbl[r].v, tbl[r].d);
      chk($sformatf("vec%0d_meas_valid", r), int'(meas_valid), int'(tbl[r].mv));
      chk($sformatf("vec%0d_period", r), int'(period), tbl[r].per);
      chk($sformatf("vec%0d_peak", r), int'(peak), tbl[r].pk);
      chk($sformatf("vec%0d_trough", r), int'(trough), tbl[r].tr);
      chk($sformatf("vec%0d_amplitude", r), int'(amplitude), tbl[r].amp);
      chk($sformatf("vec%0d_locked", r), int'(locked), int'(tbl[r].lk));
      chk($sformatf("vec%0d_timeout", r), int'(timeout), int'(tbl[r].to));
    end

    // Continuous 512-sample sine, 4 cycles: crossings at n=514, 1026, 1538.
    do_reset(1'b0);
    for (int n = 0; n < 2048; n++) step(1'b1, sine(n, 512));
    chk("sine_pub_count", pub_per.size(), 2);
    if (pub_idx.size() > 0) chk("sine_first_pub_index", pub_idx[0], 1026);
    if (pub_idx.size() > 1) chk("sine_second_pub_index", pub_idx[1], 1538);
    chk_pub("sine_pub0", 0, 512, 1023, 0, 0);
    chk_pub("sine_pub1", 1, 512, 1023, 0, 1);

    // Constant midline: cnt is 510 after the sine, saturates after 65025 more.
    i = 0;
    while (to_cnt == 0 && i < 65100) begin
      step(1'b1, 512);
      i++;
    end
    chk("timeout_sample_number", i, 65026);
    chk("timeout_locked", int'(locked), 0);
    chk("timeout_period_hold", int'(period), 512);
    chk("timeout_amplitude_hold", int'(amplitude), 1023);
    chk("timeout_state", int'(dut.state_q), int'(StSeekLow));
    step(1'b1, 512);
    chk("timeout_one_cycle", int'(timeout), 0);
    chk("timeout_pulse_count", to_cnt, 1);

    // Same sine with sample_valid toggling; garbage on invalid cycles.
    do_reset(1'b0);
    for (int n = 0; n < 1600; n++) begin
      step(1'b1, sine(n, 512));
      step(1'b0, 0);
    end
    chk("toggle_pub_count", pub_per.size(), 2);
    if (pub_idx.size() > 0) chk("toggle_first_pub_index", pub_idx[0], 1026);
    chk_pub("toggle_pub0", 0, 512, 1023, 0, 0);
    chk_pub("toggle_pub1", 1, 512, 1023, 0, 1);
    chk("toggle_no_pulse_on_invalid", bad_pulse, 0);

    // Dead-band noise after arming, then a clean 400/600 square.
    do_reset(1'b0);
    step(1'b1, 600);
    step(1'b1, 400);
    step(1'b1, 600);
    for (int n = 0; n < 1000; n++) begin
      step(1'b1, 506);
      step(1'b1, 518);
    end
    chk("noise_no_publish", pub_per.size(), 0);
    for (int n = 0; n < 3; n++) begin
      step(1'b1, 400);
      step(1'b1, 600);
    end
    chk("square_pub_count", pub_per.size(), 3);
    chk_pub("square_pub0", 0, 2002, 600, 400, 0);
    chk_pub("square_pub1", 1, 2, 600, 400, 0);
    chk_pub("square_pub2", 2, 2, 600, 400, 1);

    // Period switch 512 -> 256; transitional cycle is 511 samples.
    do_reset(1'b0);
    for (int n = 0; n < 1536; n++) step(1'b1, sine(n, 512));
    for (int m = 0; m < 520; m++) step(1'b1, sine(m, 256));
    chk("switch_pub_count", pub_per.size(), 4);
    chk_pub("switch_pub0", 0, 512, 1023, 0, 0);
    if (pub_per.size() > 1) begin
      chk("switch_transition_in_range", int'(pub_per[1] > 256 && pub_per[1] < 512), 1);
      chk("switch_transition_period", pub_per[1], 511);
      chk("switch_transition_locked", pub_lk[1], 0);
    end
    chk_pub("switch_pub2", 2, 256, 1023, 0, 0);
    chk_pub("switch_pub3", 3, 256, 1023, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
